// File: rtl/txuart.sv
// Serial UART transmitter: 8 data bits, LSB first, 1 or 2 stop bits, line idles high.
// A one-byte holding register lets the host queue the next byte so frames run back to back.
module txuart #(
    parameter int CLOCK_DIVIDE = 312,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       is_transmitting,
    output logic       tx_done
);

    localparam int PW = $clog2(CLOCK_DIVIDE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_DIVIDE - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(4 * STOP_BITS - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    qtr_q, qtr_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    logic          accept_s;
    logic          tick_s;
    logic          stop_end_s;

    // Next-state logic: prescaler, quarter-bit counter, frame FSM and holding register.
    always_comb begin
        accept_s    = tx_valid && ready_q;
        tick_s      = (state_q != TX_IDLE) && (presc_q == {PW{1'b0}});
        stop_end_s  = (state_q == TX_STOP) && tick_s && (qtr_q == STOP_LAST);

        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (state_q == TX_IDLE) begin
            presc_d = presc_q;
        end else if (tick_s) begin
            presc_d = PRESC_LAST;
        end else begin
            presc_d = presc_q - PW'(1'b1);
        end

        // A byte offered mid-frame is parked; one offered as the frame ends starts directly.
        if (accept_s && (state_q != TX_IDLE) && !stop_end_s) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d      = hold_q;
        end

        case (state_q)
            TX_IDLE: begin
                if (accept_s) begin
                    shift_d = tx_data;
                    presc_d = PRESC_LAST;
                    qtr_d   = 3'd0;
                    state_d = TX_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    tx_d    = 1'b1;
                end
            end
            TX_START: begin
                if (tick_s && (qtr_q == 3'd3)) begin
                    qtr_d     = 3'd0;
                    bit_cnt_d = 4'd8;
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                end else if (tick_s) begin
                    qtr_d     = qtr_q + 3'd1;
                end else begin
                    qtr_d     = qtr_q;
                end
            end
            TX_DATA: begin
                if (tick_s && (qtr_q == 3'd3)) begin
                    qtr_d     = 3'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    if (bit_cnt_q == 4'd1) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[1];
                    end
                end else if (tick_s) begin
                    qtr_d     = qtr_q + 3'd1;
                end else begin
                    qtr_d     = qtr_q;
                end
            end
            TX_STOP: begin
                if (stop_end_s) begin
                    done_d = 1'b1;
                    qtr_d  = 3'd0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = TX_START;
                        tx_d        = 1'b0;
                    end else if (accept_s) begin
                        shift_d     = tx_data;
                        state_d     = TX_START;
                        tx_d        = 1'b0;
                    end else begin
                        state_d     = TX_IDLE;
                        tx_d        = 1'b1;
                        busy_d      = 1'b0;
                    end
                end else if (tick_s) begin
                    qtr_d = qtr_q + 3'd1;
                end else begin
                    qtr_d = qtr_q;
                end
            end
            default: begin
                state_d     = TX_IDLE;
                tx_d        = 1'b1;
                busy_d      = 1'b0;
                hold_full_d = 1'b0;
            end
        endcase

        ready_d = !hold_full_d;
    end

    // State and output registers; reset forces the line high and drops any queued byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            presc_q     <= {PW{1'b0}};
            qtr_q       <= 3'd0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            qtr_q       <= qtr_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign tx              = tx_q;
    assign tx_ready        = ready_q;
    assign is_transmitting = busy_q;
    assign tx_done         = done_q;

endmodule
